// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clock cycles per serial bit.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write/status bundle of the buffered UART transmitter.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 clr_ovf;
    logic                 tx;
    logic                 full;
    logic                 empty;
    logic                 busy;
    logic                 tx_done;
    logic                 overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx, full, empty, busy, tx_done, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx, full, empty, busy, tx_done, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head word is readable in the same cycle it is popped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed frame FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic           sysclk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 tx_done_reg, tx_done_next;
    logic                 overflow_reg;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (bus.wr_en),
        .pop    (fifo_pop),
        .din    (bus.wr_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bit_end = (baud_cnt_reg == DIV_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= STOP_BIT;
            tx_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            tx_done_reg  <= tx_done_next;
        end
    end

    // tx is computed one cycle ahead so the line is always a flop output.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        tx_done_next  = 1'b0;
        fifo_pop      = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                tx_next       = STOP_BIT;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START;
                    tx_next    = START_BIT;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
                        state_next = STOP;
                        tx_next    = STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_next = 1'b1;
                    bit_idx_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START;
                        tx_next    = START_BIT;
                    end else begin
                        state_next = IDLE;
                        tx_next    = STOP_BIT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = STOP_BIT;
            end
        endcase
    end

    // A dropped push outranks a simultaneous clear.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    assign bus.tx       = tx_reg;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.tx_done  = tx_done_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .DEPTH    (DEPTH)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] m_q[$];
    bit         m_active;
    logic [7:0] m_byte;
    int         m_f;
    bit         m_ovf;
    bit         m_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_tx();
        if (!m_active)          return 1'b1;
        if (m_f < DIV)          return 1'b0;
        if (m_f < 9 * DIV)      return m_byte[(m_f - DIV) / DIV];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_byte   = '0;
        m_f      = 0;
        m_ovf    = 0;
        m_done   = 0;
    endtask

    task automatic model_edge();
        int pre;
        pre    = m_q.size();
        m_done = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_active) begin
            if (m_f == FRAME - 1) begin
                m_done = 1;
                if (pre > 0) begin
                    m_byte = m_q.pop_front();
                    m_f    = 0;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_f++;
            end
        end else if (pre > 0) begin
            m_byte   = m_q.pop_front();
            m_active = 1;
            m_f      = 0;
        end
        if (bus.wr_en && pre == DEPTH) m_ovf = 1;
        else if (bus.clr_ovf)          m_ovf = 0;
        if (bus.wr_en && pre < DEPTH)  m_q.push_back(bus.wr_data);
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".tx"},       32'(bus.tx),       32'(exp_tx()));
        check_val({tag, ".busy"},     32'(bus.busy),     32'(m_active));
        check_val({tag, ".tx_done"},  32'(bus.tx_done),  32'(m_done));
        check_val({tag, ".full"},     32'(bus.full),     32'(m_q.size() == DEPTH));
        check_val({tag, ".empty"},    32'(bus.empty),    32'(m_q.size() == 0));
        check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic step(input string tag = "cyc");
        @(posedge sysclk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic push_burst(input logic [7:0] b0, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = b0 + 8'(i);
            step(tag);
        end
        bus.wr_en = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, held for two edges with wr_en high.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        run(2, {tag, ".held"});
        bus.wr_en = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.clr_ovf = 1'b0;
        model_reset();

        run(3, "reset");
        reset = 1'b0;
        run(2, "post_reset");

        push_burst(8'hA5, 1, "a5");
        run(FRAME + 20, "a5");

        push_burst(8'h01, 3, "b2b");
        run(3 * FRAME + 20, "b2b");

        push_burst(8'h30, 6, "ovf");
        bus.clr_ovf = 1'b1;
        step("clr");
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        step("clr_drop");
        bus.wr_en = 1'b0;
        step("clr2");
        bus.clr_ovf = 1'b0;
        run(5 * FRAME + 20, "ovf_drain");

        push_burst(8'h70, 4, "simul");
        for (int i = 0; i < 2 * FRAME && !(m_active && m_f == FRAME - 1); i++) step("simul_wait");
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hC3;
        step("simul_edge");
        bus.wr_en = 1'b0;
        run(4 * FRAME + 20, "simul_drain");

        push_burst(8'h90, 3, "abort");
        for (int i = 0; i < FRAME && !(m_active && m_f == 50); i++) step("abort_wait");
        do_reset("abort");
        run(FRAME + 20, "abort_after");

        for (int i = 0; i < 4000; i++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 6);
            bus.wr_data = 8'($urandom);
            bus.clr_ovf = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 1999) == 0) begin
                bus.wr_en   = 1'b0;
                bus.clr_ovf = 1'b0;
                do_reset("rnd_reset");
            end else begin
                step("rnd");
            end
        end
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        run(DEPTH * FRAME + FRAME + 20, "rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning sysclk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate; DIV = CLK_FREQ/BAUD (integer), DIV >= 2.
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, >= 2.
REQ-004 sysclk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  push request; one byte per asserted cycle.
REQ-007 wr_data  input  8  byte to push.
REQ-008 clr_ovf  input  1  clears overflow.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 tx_done  output  1  one-cycle pulse at end of each stop bit.
REQ-014 overflow  output  1  sticky: a push was dropped.

Function
REQ-015 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly DIV cycles.
REQ-016 FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if FIFO non-empty, pop head into shift register, enter START, reset baud counter.
REQ-018 START/DATA/STOP: baud counter counts 0..DIV-1; bit boundary when counter = DIV-1.
REQ-019 DATA SHALL use 3-bit bit index; after index 7 boundary, enter STOP.
REQ-020 STOP boundary: pulse tx_done; if FIFO non-empty, pop and enter START directly (no idle gap); else enter IDLE.
REQ-021 tx SHALL be driven from a register (glitch-free); full, empty, busy registered or decoded from registers only.
REQ-022 Latency: wr_en at edge k into empty FIFO with FSM in IDLE -> empty=0 after edge k, tx=0 after edge k+1.
REQ-023 Push when full SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-024 Push and pop in same cycle with FIFO not full SHALL both occur; count unchanged.
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-026 clr_ovf clears overflow; if a dropped push coincides, overflow set wins.
REQ-027 wr_en SHALL be ignored while reset is high.

Reset
REQ-028 Reset asserted SHALL immediately force: state IDLE, tx=1, FIFO empty (pointers, count = 0), empty=1, full=0, busy=0, tx_done=0, overflow=0, baud counter=0, bit index=0.
REQ-029 Reset mid-frame SHALL abort the frame; line returns high at once; pending bytes discarded.

Structure
REQ-030 FSM state encoding and frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1) SHALL live in shared package uart_pkg.
REQ-031 FIFO SHALL be a separate sub-module sync_fifo (parameter WIDTH, DEPTH; ports push, pop, din, dout, full, empty).
REQ-032 Baud counter and FSM SHALL reside in uart_tx_fifo itself.

Verification (CLK_FREQ=16, BAUD=1 -> DIV=16, DEPTH=4)
REQ-033 Push 0xA5 once -> tx low 16 cycles, then 1,0,1,0,0,1,0,1 each 16 cycles, high 16 cycles; tx_done at cycle 160 of frame; busy falls after.
REQ-034 Push 0x01,0x02,0x03 back-to-back -> three contiguous 160-cycle frames, no idle gap, three tx_done pulses, empty=1 at end.
REQ-035 Push 6 bytes in consecutive cycles while idle -> first popped, 4 stored, full=1, 6th dropped, overflow=1; 5 frames transmitted.
REQ-036 Assert clr_ovf after REQ-035 -> overflow=0 next cycle; assert clr_ovf with dropped push -> overflow stays 1.
REQ-037 Assert reset at cycle 50 of a frame with 2 bytes queued -> tx=1, busy=0, empty=1 immediately; no further frames after release.
REQ-038 Simultaneous push and STOP-boundary pop with FIFO at 3 entries -> count stays 3, next frame starts without gap.
